// File: rtl/aes_pkg.sv
// aes_pkg: widths, aes_core size codes and the request FSM state type
// shared by the aes_core initiator and its neighbours.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  localparam logic [1:0] AES_128 = 2'd0;
  localparam logic [1:0] AES_192 = 2'd1;
  localparam logic [1:0] AES_256 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT
  } state_t;

endpackage

// File: rtl/aes_req_ctrl.sv
// aes_req_ctrl: stream-to-aes_core initiator, one block in flight, ECB/CBC.
// Ports: in_* / out_* valid-ready block streams, key/mode/dec/iv controls,
// err_o sticky timeout, core_* drive and observe aes_core.
module aes_req_ctrl
  import aes_pkg::*;
#(
  parameter bit CBC_EN  = 1'b1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_i,
  input  logic             mode_cbc_i,
  input  logic             dec_i,
  input  logic             iv_load_i,
  input  logic [BLK_W-1:0] iv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             err_o,
  output logic             core_load_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_data_o,
  output logic [1:0]       core_size_o,
  output logic             core_dec_o,
  input  logic [BLK_W-1:0] core_data_i,
  input  logic             core_busy_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic [KEY_W-1:0] key_q;
  logic [BLK_W-1:0] data_q;
  logic [BLK_W-1:0] chain_q;
  logic [BLK_W-1:0] next_q;
  logic [BLK_W-1:0] res_q;
  logic             dec_q;
  logic             cbc_q;
  logic             vld_q;
  logic             err_q;
  logic             alive_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             cbc_in;
  logic             iv_take;
  logic             done;
  logic             expire;
  logic [BLK_W-1:0] chain_in;

  // alive_q keeps in_ready low while reset is asserted
  assign in_ready_o = alive_q & (state_q == IDLE) & ~vld_q;
  assign accept     = in_valid_i & in_ready_o;
  assign cbc_in     = CBC_EN & mode_cbc_i;
  assign iv_take    = CBC_EN & iv_load_i & (state_q == IDLE);
  // a same-cycle IV load feeds the block being accepted
  assign chain_in   = iv_take ? iv_i : chain_q;
  assign done       = (state_q == WAIT) & ~core_busy_i;
  assign expire     = (state_q == WAIT) & core_busy_i
                    & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    core_load_o = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        core_load_o = 1'b1;
        state_d     = ARM;
      end
      ARM:  if (core_busy_i) state_d = WAIT;
      WAIT: if (done || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      data_q  <= '0;
      chain_q <= '0;
      next_q  <= '0;
      res_q   <= '0;
      dec_q   <= 1'b0;
      cbc_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      alive_q <= 1'b1;
      if (iv_take) chain_q <= iv_i;
      if (accept) begin
        key_q  <= key_i;
        dec_q  <= dec_i;
        cbc_q  <= cbc_in;
        data_q <= (cbc_in & ~dec_i) ? (in_data_i ^ chain_in)
                                    : in_data_i;
        if (cbc_in & dec_i) next_q <= in_data_i;
      end
      if (vld_q & out_ready_i) vld_q <= 1'b0;
      if (done) begin
        vld_q <= 1'b1;
        res_q <= (cbc_q & dec_q) ? (core_data_i ^ chain_q)
                                 : core_data_i;
        if (cbc_q) chain_q <= dec_q ? next_q : core_data_i;
      end
      if (expire) err_q <= 1'b1;
      if (core_busy_i && (state_q == WAIT) && !expire)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = res_q;
  assign err_o       = err_q;
  assign core_key_o  = key_q;
  assign core_data_o = data_q;
  assign core_dec_o  = dec_q;
  assign core_size_o = AES_128;

endmodule

// File: tb/tb_aes_req_ctrl.sv
// tb_aes_req_ctrl: bench for aes_req_ctrl with a behavioural AES-128 core
// as responder and a block-level ECB/CBC reference model.
module tb_aes_req_ctrl;

  localparam int TIMEOUT = 64;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P3  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C3  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] E3  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key_i = '0;
  logic         mode_cbc_i = 1'b0;
  logic         dec_i = 1'b0;
  logic         iv_load_i = 1'b0;
  logic [127:0] iv_i = '0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] in_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [127:0] out_data_o;
  logic         err_o;
  logic         core_load_o;
  logic [255:0] core_key_o;
  logic [127:0] core_data_o;
  logic [1:0]   core_size_o;
  logic         core_dec_o;
  logic [127:0] core_data_i = '0;
  logic         core_busy_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int nload = 0;
  int ccnt = 0;
  bit stuck = 1'b0;
  logic [127:0] cres = '0;

  aes_req_ctrl #(.CBC_EN(1'b1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .mode_cbc_i(mode_cbc_i),
    .dec_i(dec_i), .iv_load_i(iv_load_i), .iv_i(iv_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .err_o(err_o),
    .core_load_o(core_load_o), .core_key_o(core_key_o),
    .core_data_o(core_data_o), .core_size_o(core_size_o),
    .core_dec_o(core_dec_o), .core_data_i(core_data_i),
    .core_busy_i(core_busy_i)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb[256];
  logic [7:0] isb[256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, inv, s;
      x = 8'(i);
      inv = 8'h01;
      repeat (254) inv = gm(inv, x);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[i] = s;
      isb[s] = x;
    end
  end

  function automatic logic [10:0][127:0] kexp(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [10:0][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v, input logic inv);
    logic [7:0] m[4];
    logic [7:0] a[4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = v[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gm(m[(j-r+4)%4], a[j]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] k,
                                       input logic [127:0] d,
                                       input logic dec);
    logic [10:0][127:0] rk;
    logic [7:0] s[16];
    logic [127:0] v;
    rk = kexp(k);
    v = d ^ (dec ? rk[10] : rk[0]);
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          v[127-8*(4*c+j) -: 8] = dec ? isb[s[j+4*((c-j+4)%4)]]
                                      : sb[s[j+4*((c+j)%4)]];
      if (!dec) begin
        if (r < 10) v = mix(v, 1'b0);
        v ^= rk[r];
      end else begin
        v ^= rk[10-r];
        if (r < 10) v = mix(v, 1'b1);
      end
    end
    return v;
  endfunction

  // ---------------- aes_core responder ----------------
  // busy rises the cycle after load and drops after the round count
  always @(posedge clk) begin
    if (core_load_o === 1'b1) begin
      core_busy_i <= 1'b1;
      ccnt <= core_dec_o ? 22 : 11;
      cres <= aes(core_key_o[255:128], core_data_o, core_dec_o);
    end else if (core_busy_i && !stuck) begin
      if (ccnt == 0) begin
        core_busy_i <= 1'b0;
        core_data_i <= cres;
      end else begin
        ccnt <= ccnt - 1;
      end
    end
  end

  always @(posedge clk) if (core_load_o === 1'b1) nload <= nload + 1;

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [255:0] k, input logic m, input logic d,
                      input logic [127:0] x, input logic ivl,
                      input logic [127:0] iv, output bit ok);
    int w;
    key_i = k; mode_cbc_i = m; dec_i = d; in_data_i = x;
    iv_load_i = ivl; iv_i = iv; in_valid_i = 1'b1;
    w = 0;
    while (in_ready_o !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    ok = (in_ready_o === 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    iv_load_i = 1'b0;
  endtask

  task automatic get_out(input int hold, output logic [127:0] d,
                         output int lat, output bit ok,
                         output bit stable, output bit clr);
    lat = 0;
    out_ready_i = 1'b0;
    while (out_valid_o !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    ok = (out_valid_o === 1'b1);
    d = out_data_o;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (out_valid_o !== 1'b1 || out_data_o !== d || in_ready_o !== 1'b0)
        stable = 1'b0;
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    clr = (out_valid_o === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, err_o, core_load_o, core_dec_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, want 00000",
               {in_ready_o, out_valid_o, err_o, core_load_o, core_dec_o});
    end
    n_cmp++;
    if ({core_key_o, core_data_o, out_data_o, core_size_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got key %h data %h out %h size %h, want all 0",
               core_key_o, core_data_o, out_data_o, core_size_o);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, want 1", in_ready_o);
    end
  endtask

  task automatic test_ecb_enc;
    logic [127:0] got; int lat, n0; bit ok, st, clr;
    n0 = nload;
    send({K1, 128'hdeadbeef}, 1'b0, 1'b0, P1, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== C1) begin
      n_bad++; $display("FAIL ecb_enc_data: got %h, want %h", got, C1);
    end
    n_cmp++;
    if (lat !== 14) begin
      n_bad++; $display("FAIL ecb_enc_latency: got %0d, want 14", lat);
    end
    n_cmp++;
    if (nload - n0 !== 1) begin
      n_bad++; $display("FAIL ecb_enc_loads: got %0d, want 1", nload - n0);
    end
    n_cmp++;
    if (!clr) begin
      n_bad++; $display("FAIL ecb_enc_clear: got valid %b, want 0", out_valid_o);
    end
  endtask

  task automatic test_ecb_dec;
    logic [127:0] got; int lat; bit ok, st, clr;
    send({K1, 128'h0}, 1'b0, 1'b1, C1, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== P1) begin
      n_bad++; $display("FAIL ecb_dec_data: got %h, want %h", got, P1);
    end
    n_cmp++;
    if (lat !== 25) begin
      n_bad++; $display("FAIL ecb_dec_latency: got %0d, want 25", lat);
    end
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++; $display("FAIL ecb_dec_err: got %b, want 0", err_o);
    end
  endtask

  task automatic test_cbc_enc;
    logic [127:0] got, p2, exp; int lat; bit ok, st, clr;
    iv_i = IV3; iv_load_i = 1'b1;
    @(posedge clk); #1;
    iv_load_i = 1'b0;
    send({K3, 128'h0}, 1'b1, 1'b0, P3, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== C3) begin
      n_bad++; $display("FAIL cbc_enc_data: got %h, want %h", got, C3);
    end
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = aes(K3, p2 ^ C3, 1'b0);
    send({K3, 128'h0}, 1'b1, 1'b0, p2, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL cbc_enc_chain: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_cbc_dec;
    logic [127:0] got; int lat; bit ok, st, clr;
    send({K3, 128'h0}, 1'b1, 1'b1, C3, 1'b1, IV3, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== P3) begin
      n_bad++; $display("FAIL cbc_dec_data: got %h, want %h", got, P3);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] got; int lat, n0; bit ok, st, clr;
    n0 = nload;
    send({K1, 128'h0}, 1'b0, 1'b0, P1, 1'b0, '0, ok);
    key_i = {K3, 128'h0}; mode_cbc_i = 1'b0; dec_i = 1'b0;
    in_data_i = P3; in_valid_i = 1'b1;
    get_out(20, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== C1) begin
      n_bad++; $display("FAIL bp_data: got %h, want %h", got, C1);
    end
    n_cmp++;
    if (!st) begin
      n_bad++; $display("FAIL bp_hold: got unstable output or ready, want held");
    end
    n_cmp++;
    if (nload - n0 !== 1) begin
      n_bad++; $display("FAIL bp_no_accept: got %0d loads, want 1", nload - n0);
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL bp_ready_after: got %b, want 1", in_ready_o);
    end
    send({K3, 128'h0}, 1'b0, 1'b0, P3, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== E3) begin
      n_bad++; $display("FAIL bp_next_data: got %h, want %h", got, E3);
    end
  endtask

  task automatic test_random;
    logic [255:0] k; logic [127:0] x, iv, exp, got, chain;
    logic m, d, ivl; int lat; bit ok, st, clr;
    chain = '0;
    for (int b = 0; b < 12; b++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      iv = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      ivl = (b == 0) || ($urandom_range(0, 3) == 0);
      if (ivl) chain = iv;
      if (!m) begin
        exp = aes(k[255:128], x, d);
      end else if (!d) begin
        exp = aes(k[255:128], x ^ chain, 1'b0);
        chain = exp;
      end else begin
        exp = aes(k[255:128], x, 1'b1) ^ chain;
        chain = x;
      end
      send(k, m, d, x, ivl, iv, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand_accept[%0d]: got ready 0, want 1", b);
      end
      get_out($urandom_range(0, 3), got, lat, ok, st, clr);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rand_data[%0d] cbc=%b dec=%b: got %h, want %h",
                 b, m, d, got, exp);
      end
      n_cmp++;
      if (!st || !clr) begin
        n_bad++;
        $display("FAIL rand_handshake[%0d]: got stable=%b clear=%b, want 1 1",
                 b, st, clr);
      end
    end
  endtask

  task automatic test_timeout;
    int c; bit ok;
    stuck = 1'b1;
    send({K1, 128'h0}, 1'b0, 1'b0, P1, 1'b0, '0, ok);
    c = 0;
    while (err_o !== 1'b1 && c < 200) begin
      @(posedge clk); #1; c++;
    end
    n_cmp++;
    if (c < TIMEOUT || c > TIMEOUT + 4) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d, want %0d..%0d", c, TIMEOUT, TIMEOUT + 4);
    end
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_idle: got valid %b ready %b, want 0 1",
               out_valid_o, in_ready_o);
    end
    stuck = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: got %b, want 1", err_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] got; int lat; bit ok, st, clr;
    send({K1, 128'h0}, 1'b0, 1'b0, P1, 1'b0, '0, ok);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, err_o, core_load_o, core_dec_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL midreset_ctrl: got %b, want 00000",
               {in_ready_o, out_valid_o, err_o, core_load_o, core_dec_o});
    end
    n_cmp++;
    if ({core_key_o, core_data_o, out_data_o} !== '0) begin
      n_bad++;
      $display("FAIL midreset_data: got key %h data %h out %h, want all 0",
               core_key_o, core_data_o, out_data_o);
    end
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send({K1, 128'h0}, 1'b0, 1'b0, P1, 1'b0, '0, ok);
    get_out(0, got, lat, ok, st, clr);
    n_cmp++;
    if (got !== C1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_recover: got %h err %b, want %h err 0", got, err_o, C1);
    end
  endtask

  initial begin
    test_reset;
    test_ecb_enc;
    test_ecb_dec;
    test_cbc_enc;
    test_cbc_dec;
    test_backpressure;
    test_random;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
